// File: rtl/uart_pkg.sv
// Shared UART parity definitions: parity-type encodings, RX checker state encoding,
// the minimum frame length and the parity-bit helper used by both TX and RX paths.
package uart_pkg;

   localparam int MIN_DATA_LEN = 5;

   typedef enum logic [1:0] {
      PAR_EVEN  = 2'b00,
      PAR_ODD   = 2'b01,
      PAR_MARK  = 2'b10,
      PAR_SPACE = 2'b11
   } par_type_t;

   typedef enum logic [1:0] {
      RX_IDLE   = 2'b00,
      RX_DATA   = 2'b01,
      RX_PARITY = 2'b10
   } rx_state_t;

   // Turns the XOR of the (already masked) data bits into the line parity bit.
   function automatic logic par_from_xor(input logic data_xor, input logic [1:0] par_type);
      logic result;
      case (par_type)
         PAR_EVEN: result = data_xor;
         PAR_ODD:  result = ~data_xor;
         PAR_MARK: result = 1'b1;
         default:  result = 1'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/uart_parity_rx_chk.sv
// RX parity checker: frame FSM, running XOR accumulator, done/error pulses and the
// saturating parity-error counter. Frame configuration is latched on rx_start.
module uart_parity_rx_chk
   import uart_pkg::*;
#(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 par_en,
   input  logic [1:0]           par_type,
   input  logic [3:0]           len,
   input  logic                 rx_start,
   input  logic                 rx_bit_valid,
   input  logic                 rx_bit,
   input  logic                 err_clr,
   output logic                 rx_par_done,
   output logic                 rx_par_err,
   output logic [CNT_WIDTH-1:0] err_count
);

   localparam logic [CNT_WIDTH-1:0] ERR_MAX = '1;

   rx_state_t  state_reg, state_next;
   logic       acc_reg, acc_next;
   logic [3:0] cnt_reg, cnt_next;
   logic       par_en_reg, par_en_next;
   logic [1:0] par_type_reg, par_type_next;
   logic [3:0] len_reg, len_next;
   logic       done_reg, done_next;
   logic       err_reg, err_next;
   logic [CNT_WIDTH-1:0] err_count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= RX_IDLE;
         acc_reg      <= 1'b0;
         cnt_reg      <= 4'd0;
         par_en_reg   <= 1'b0;
         par_type_reg <= 2'b00;
         len_reg      <= 4'd0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         acc_reg      <= acc_next;
         cnt_reg      <= cnt_next;
         par_en_reg   <= par_en_next;
         par_type_reg <= par_type_next;
         len_reg      <= len_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      acc_next      = acc_reg;
      cnt_next      = cnt_reg;
      par_en_next   = par_en_reg;
      par_type_next = par_type_reg;
      len_next      = len_reg;
      done_next     = 1'b0;
      err_next      = 1'b0;

      // A start bit always wins: any frame in progress is dropped silently.
      if (rx_start) begin
         state_next    = RX_DATA;
         acc_next      = 1'b0;
         cnt_next      = 4'd0;
         par_en_next   = par_en;
         par_type_next = par_type;
         len_next      = len;
      end else begin
         case (state_reg)
            RX_DATA: begin
               if (rx_bit_valid) begin
                  acc_next = acc_reg ^ rx_bit;
                  cnt_next = cnt_reg + 4'd1;
                  if (cnt_reg + 4'd1 == len_reg) begin
                     if (par_en_reg) begin
                        state_next = RX_PARITY;
                     end else begin
                        state_next = RX_IDLE;
                        done_next  = 1'b1;
                     end
                  end
               end
            end
            RX_PARITY: begin
               if (rx_bit_valid) begin
                  state_next = RX_IDLE;
                  done_next  = 1'b1;
                  err_next   = rx_bit != par_from_xor(acc_reg, par_type_reg);
               end
            end
            default: ;
         endcase
      end
   end

   // Clear and a same-cycle error pulse net out to a count of one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count_reg <= '0;
      end else if (err_reg) begin
         if (err_clr) begin
            err_count_reg <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end else if (err_count_reg != ERR_MAX) begin
            err_count_reg <= err_count_reg + 1'b1;
         end
      end else if (err_clr) begin
         err_count_reg <= '0;
      end
   end

   assign rx_par_done = done_reg;
   assign rx_par_err  = err_reg;
   assign err_count   = err_count_reg;

endmodule

// File: rtl/uart_parity_engine.sv
// UART parity engine: registered TX parity for captured words plus the RX parity
// checker. The data-length clamp and bit mask live here and feed both paths.
module uart_parity_engine
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  par_en,
   input  logic [1:0]            par_type,
   input  logic [3:0]            data_len,
   input  logic                  tx_data_valid,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_busy,
   output logic                  tx_par_bit,
   output logic                  tx_par_valid,
   input  logic                  rx_start,
   input  logic                  rx_bit_valid,
   input  logic                  rx_bit,
   output logic                  rx_par_done,
   output logic                  rx_par_err,
   input  logic                  err_clr,
   output logic [CNT_WIDTH-1:0]  err_count
);

   logic [3:0]            len_clamp;
   logic [DATA_WIDTH-1:0] len_mask;
   logic                  capture;
   logic                  tx_par_bit_next;

   always_comb begin
      len_clamp = data_len;
      if (data_len < 4'(MIN_DATA_LEN)) begin
         len_clamp = 4'(MIN_DATA_LEN);
      end else if (data_len > 4'(DATA_WIDTH)) begin
         len_clamp = 4'(DATA_WIDTH);
      end
   end

   generate
      for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
         assign len_mask[gi] = 4'(gi) < len_clamp;
      end
   endgenerate

   assign capture         = tx_data_valid && !tx_busy;
   assign tx_par_bit_next = par_en ? par_from_xor(^(tx_data & len_mask), par_type) : 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_par_bit   <= 1'b0;
         tx_par_valid <= 1'b0;
      end else if (capture) begin
         tx_par_bit   <= tx_par_bit_next;
         tx_par_valid <= par_en;
      end
   end

   uart_parity_rx_chk #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_rx_chk (
      .clk          (clk),
      .rst          (rst),
      .par_en       (par_en),
      .par_type     (par_type),
      .len          (len_clamp),
      .rx_start     (rx_start),
      .rx_bit_valid (rx_bit_valid),
      .rx_bit       (rx_bit),
      .err_clr      (err_clr),
      .rx_par_done  (rx_par_done),
      .rx_par_err   (rx_par_err),
      .err_count    (err_count)
   );

endmodule
